// File: rtl/sub_bytes_seq.sv
// AES SubBytes over a 128-bit state, LANES S-box lookups per cycle, valid/ready on both sides.
// Define SUB_BYTES_SEQ_INV_EN to build the inverse S-box and honour in_inv; otherwise in_inv is ignored.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int BEATS = (LANES > 0) ? (16 / LANES) : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Table entry x is the S-box output for input byte x (entry 0 is the leftmost byte).
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_BYTES_SEQ_INV_EN
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    logic inv_q;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q;
    logic [127:0]    blk_q;
    logic [127:0]    blk_sub;
    logic [127:0]    out_q;
    logic            accept;

    assign out_state = out_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready = in_ready & rst_n;
        if (in_valid && in_ready) begin
            state_d = BUSY;
        end
    end

    // The working block is substituted in place, one group of LANES bytes per beat.
    always_comb begin
        blk_sub = blk_q;
        for (int j = 0; j < LANES; j++) begin
`ifdef SUB_BYTES_SEQ_INV_EN
            blk_sub[(int'(beat_q) * LANES + j) * 8 +: 8] =
                inv_q ? INV_SBOX[blk_q[(int'(beat_q) * LANES + j) * 8 +: 8]]
                      : FWD_SBOX[blk_q[(int'(beat_q) * LANES + j) * 8 +: 8]];
`else
            blk_sub[(int'(beat_q) * LANES + j) * 8 +: 8] =
                FWD_SBOX[blk_q[(int'(beat_q) * LANES + j) * 8 +: 8]];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            blk_q   <= '0;
            out_q   <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                blk_q  <= in_state;
                beat_q <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
                inv_q  <= in_inv;
`endif
            end else if (state_q == BUSY) begin
                blk_q <= blk_sub;
                // out_state only moves when a whole block has completed.
                if (beat_q == LAST_BEAT) begin
                    out_q <= blk_sub;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

endmodule
